// File: rtl/bip_debug_ctrl.sv
// -----------------------------------------------------------------------------
// bip_debug_ctrl
// Run/step/debug sequencer placed between the UART RX/TX and the BIP core.
// Single-byte commands from the UART receiver start a continuous run ('R'),
// a single step ('S') or clear the core ('C'). Executed cycles are counted.
// After every stop a 6-byte report {PC, ACC, CNT} (MSB first) is streamed to
// the UART transmitter.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-low reset
//   rx_data    in   [7:0] received command byte
//   rx_done    in   one-cycle pulse, rx_data valid
//   tx_busy    in   transmitter busy
//   tx_done    in   one-cycle pulse, byte sent
//   pc_in      in   [len_addr-1:0] current BIP program counter
//   acc_in     in   [len_data-1:0] current BIP accumulator
//   opcode_in  in   [len_opcode-1:0] opcode at the current PC
//   cpu_ena    out  BIP clock enable (high only in RUN and STEP)
//   bip_reset  out  active-low reset to the BIP core
//   tx_start   out  one-cycle transmit request
//   tx_data    out  [7:0] byte to transmit, stable until tx_done
//   halted     out  HALT reached, program finished
//   busy       out  high in every state except IDLE and HALTED
// -----------------------------------------------------------------------------
module bip_debug_ctrl #(
  parameter int len_data    = 16,
  parameter int len_addr    = 11,
  parameter int len_opcode  = 3,
  parameter int halt_opcode = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  input  logic [len_addr-1:0]   pc_in,
  input  logic [len_data-1:0]   acc_in,
  input  logic [len_opcode-1:0] opcode_in,
  output logic                  cpu_ena,
  output logic                  bip_reset,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  halted,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_SEND   = 3'd4,
    ST_WAIT   = 3'd5,
    ST_HALTED = 3'd6
  } state_t;

  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_CLEAR = 8'h43;
  localparam logic [2:0] LAST_IDX  = 3'd5;

  // Counter stops at all-ones instead of wrapping to zero.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic        halt_flag_r, halt_flag_s;
  logic [47:0] shreg_r, shreg_s;
  logic [2:0]  idx_r, idx_s;
  logic        tx_start_r, tx_start_s;
  logic [7:0]  tx_data_r, tx_data_s;
  logic        halted_r, halted_s;
  logic        bip_reset_r, bip_reset_s;
  logic        cpu_ena_r, cpu_ena_s;
  logic        busy_r, busy_s;
  logic        is_halt_s;

  assign is_halt_s = (opcode_in == len_opcode'(halt_opcode));

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    halt_flag_s = halt_flag_r;
    shreg_s     = shreg_r;
    idx_s       = idx_r;
    tx_start_s  = 1'b0;
    tx_data_s   = tx_data_r;
    halted_s    = halted_r;
    bip_reset_s = 1'b1;

    case (state_r)
      ST_IDLE: begin
        if (rx_done) begin
          if (rx_data == CMD_RUN) begin
            state_s     = ST_RUN;
            halt_flag_s = 1'b0;
          end else if (rx_data == CMD_STEP) begin
            state_s     = ST_STEP;
            halt_flag_s = 1'b0;
          end else if (rx_data == CMD_CLEAR) begin
            bip_reset_s = 1'b0;
            cnt_s       = 16'd0;
            halted_s    = 1'b0;
            halt_flag_s = 1'b0;
            state_s     = ST_IDLE;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_HALTED: begin
        // Only a clear leaves HALTED; run/step bytes are dropped here.
        if (rx_done && (rx_data == CMD_CLEAR)) begin
          bip_reset_s = 1'b0;
          cnt_s       = 16'd0;
          halted_s    = 1'b0;
          halt_flag_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_HALTED;
        end
      end

      ST_RUN: begin
        // The HALT cycle itself is enabled but not counted.
        if (is_halt_s) begin
          halt_flag_s = 1'b1;
          state_s     = ST_LOAD;
        end else begin
          cnt_s   = sat_inc(cnt_r);
          state_s = ST_RUN;
        end
      end

      ST_STEP: begin
        if (is_halt_s) begin
          halt_flag_s = 1'b1;
        end else begin
          cnt_s = sat_inc(cnt_r);
        end
        state_s = ST_LOAD;
      end

      ST_LOAD: begin
        // cpu_ena is already low, so pc_in/acc_in are the post-execution values.
        shreg_s = {16'(pc_in), 16'(acc_in), cnt_r};
        idx_s   = 3'd0;
        state_s = ST_SEND;
      end

      ST_SEND: begin
        if (!tx_busy) begin
          tx_start_s = 1'b1;
          tx_data_s  = shreg_r[47:40];
          state_s    = ST_WAIT;
        end else begin
          state_s = ST_SEND;
        end
      end

      ST_WAIT: begin
        if (tx_done) begin
          if (idx_r == LAST_IDX) begin
            halted_s = halt_flag_r;
            state_s  = halt_flag_r ? ST_HALTED : ST_IDLE;
          end else begin
            idx_s   = idx_r + 3'd1;
            shreg_s = {shreg_r[39:0], 8'h00};
            state_s = ST_SEND;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Registered from the next state so they line up with state_r (Moore).
    cpu_ena_s = (state_s == ST_RUN) || (state_s == ST_STEP);
    busy_s    = (state_s != ST_IDLE) && (state_s != ST_HALTED);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'd0;
      halt_flag_r <= 1'b0;
      shreg_r     <= 48'd0;
      idx_r       <= 3'd0;
      tx_start_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      halted_r    <= 1'b0;
      bip_reset_r <= 1'b0;
      cpu_ena_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      halt_flag_r <= halt_flag_s;
      shreg_r     <= shreg_s;
      idx_r       <= idx_s;
      tx_start_r  <= tx_start_s;
      tx_data_r   <= tx_data_s;
      halted_r    <= halted_s;
      bip_reset_r <= bip_reset_s;
      cpu_ena_r   <= cpu_ena_s;
      busy_r      <= busy_s;
    end
  end

  assign cpu_ena   = cpu_ena_r;
  assign bip_reset = bip_reset_r;
  assign tx_start  = tx_start_r;
  assign tx_data   = tx_data_r;
  assign halted    = halted_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_bip_debug_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bip_debug_ctrl
// Self-checking bench for bip_debug_ctrl. A tiny BIP model advances PC and
// ACC (ACC += 0x1234 per executed instruction) whenever cpu_ena is high on a
// non-HALT opcode. A UART-TX model answers tx_start with busy then tx_done.
// Expected report bytes are queued when a command is sent and popped when the
// DUT raises tx_start.
// -----------------------------------------------------------------------------
module tb_bip_debug_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic [10:0] pc_in;
  logic [15:0] acc_in;
  logic [2:0]  opcode_in;
  logic        cpu_ena, bip_reset, tx_start, halted, busy;
  logic [7:0]  tx_data;

  bip_debug_ctrl dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .tx_busy(tx_busy), .tx_done(tx_done), .pc_in(pc_in), .acc_in(acc_in),
    .opcode_in(opcode_in), .cpu_ena(cpu_ena), .bip_reset(bip_reset),
    .tx_start(tx_start), .tx_data(tx_data), .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  // BIP model
  logic [10:0] pc_m;
  logic [15:0] acc_m;
  int          halt_pc = 3;
  logic        force_halt = 1'b0;

  assign pc_in     = pc_m;
  assign acc_in    = acc_m;
  assign opcode_in = (force_halt || (int'(pc_m) == halt_pc)) ? 3'd0 : 3'd1;

  always_ff @(posedge clk) begin
    if (!bip_reset) begin
      pc_m  <= 11'd0;
      acc_m <= 16'd0;
    end else if (cpu_ena && (opcode_in != 3'd0)) begin
      pc_m  <= pc_m + 11'd1;
      acc_m <= acc_m + 16'h1234;
    end
  end

  // Bookkeeping
  int n_chk = 0;
  int n_err = 0;
  int n_ena = 0;
  int n_tx = 0;
  int n_done = 0;
  int n_rlow = 0;
  logic busy_hold = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic push_report(input logic [47:0] r);
    for (int i = 0; i < 6; i++) exp_q.push_back(r[47-8*i -: 8]);
  endtask

  // Monitor + UART TX model, sampled on the falling edge.
  initial begin
    int timer;
    logic [7:0] sent;
    timer = 0;
    sent = 8'h00;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (cpu_ena === 1'b1) n_ena++;
      if (bip_reset === 1'b0 && reset === 1'b1) n_rlow++;
      if (!reset) begin
        timer = 0;
      end else if (tx_start === 1'b1) begin
        n_tx++;
        if (exp_q.size() == 0) begin
          chk("unexpected_tx_byte", {56'd0, tx_data}, 64'hFFFF_FFFF);
        end else begin
          chk("report_byte", {56'd0, tx_data}, {56'd0, exp_q.pop_front()});
        end
        sent = tx_data;
        timer = 3;
      end else if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          chk("tx_data_stable", {56'd0, tx_data}, {56'd0, sent});
          tx_done = 1'b1;
          n_done++;
        end
      end
      tx_busy = busy_hold || (timer > 0);
    end
  end

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk);
    rx_data = c;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    busy_hold = 1'b0;
    force_halt = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("bip_reset_after_release", {63'd0, bip_reset}, 64'd1);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    int          ena;
    int          ntx;
    logic [47:0] rpt;
    logic        hlt;
    int          rlow;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int b_ena, b_tx, b_rl, b_done, guard;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cpu_ena",   {63'd0, cpu_ena},   64'd0);
    chk("rst_bip_reset", {63'd0, bip_reset}, 64'd0);
    chk("rst_tx_start",  {63'd0, tx_start},  64'd0);
    chk("rst_tx_data",   {56'd0, tx_data},   64'd0);
    chk("rst_halted",    {63'd0, halted},    64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("bip_reset_first_clock", {63'd0, bip_reset}, 64'd1);
    repeat (2) @(negedge clk);

    // Command table, program halts at PC 3
    tbl[0] = '{8'h41, 0, 0, 48'h0,              1'b0, 0};
    tbl[1] = '{8'h53, 1, 6, 48'h0001_1234_0001, 1'b0, 0};
    tbl[2] = '{8'h53, 1, 6, 48'h0002_2468_0002, 1'b0, 0};
    tbl[3] = '{8'h52, 2, 6, 48'h0003_369C_0003, 1'b1, 0};
    tbl[4] = '{8'h52, 0, 0, 48'h0,              1'b1, 0};
    tbl[5] = '{8'h53, 0, 0, 48'h0,              1'b1, 0};
    tbl[6] = '{8'h43, 0, 0, 48'h0,              1'b0, 1};
    tbl[7] = '{8'h53, 1, 6, 48'h0001_1234_0001, 1'b0, 0};

    for (int i = 0; i < 8; i++) begin
      b_ena = n_ena;
      b_tx  = n_tx;
      b_rl  = n_rlow;
      if (tbl[i].ntx != 0) push_report(tbl[i].rpt);
      send_cmd(tbl[i].cmd);
      repeat (80) @(negedge clk);
      chk("tbl_ena_cycles", 64'(n_ena - b_ena), 64'(tbl[i].ena));
      chk("tbl_tx_count",   64'(n_tx - b_tx),   64'(tbl[i].ntx));
      chk("tbl_bip_rst_low", 64'(n_rlow - b_rl), 64'(tbl[i].rlow));
      chk("tbl_halted",     {63'd0, halted},    {63'd0, tbl[i].hlt});
      chk("tbl_busy",       {63'd0, busy},      64'd0);
      chk("tbl_queue_empty", 64'(exp_q.size()), 64'd0);
    end

    // Fresh reset, run to HALT at PC 3
    do_reset();
    halt_pc = 3;
    b_ena = n_ena;
    b_tx  = n_tx;
    push_report(48'h0003_369C_0003);
    send_cmd(8'h52);
    repeat (80) @(negedge clk);
    chk("run_ena_cycles", 64'(n_ena - b_ena), 64'd4);
    chk("run_tx_count",   64'(n_tx - b_tx),   64'd6);
    chk("run_halted",     {63'd0, halted},    64'd1);
    chk("run_busy",       {63'd0, busy},      64'd0);

    // Long run with 'S' injected mid-run, then tx_busy held at report start
    do_reset();
    halt_pc = 40;
    busy_hold = 1'b1;
    b_ena = n_ena;
    push_report({16'd40, 16'(40 * 16'h1234), 16'd40});
    send_cmd(8'h52);
    repeat (10) @(negedge clk);
    send_cmd(8'h53);
    guard = 0;
    while (!((n_ena - b_ena >= 41) && (cpu_ena == 1'b0)) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("long_run_ena_cycles", 64'(n_ena - b_ena), 64'd41);
    b_tx = n_tx;
    repeat (20) @(negedge clk);
    chk("busy_hold_no_tx", 64'(n_tx - b_tx), 64'd0);
    chk("busy_hold_busy",  {63'd0, busy},    64'd1);
    busy_hold = 1'b0;
    repeat (80) @(negedge clk);
    chk("busy_hold_tx_count", 64'(n_tx - b_tx), 64'd6);
    chk("long_run_halted",    {63'd0, halted},  64'd1);
    chk("long_run_queue",     64'(exp_q.size()), 64'd0);

    // Reset in the middle of a report
    do_reset();
    halt_pc = 3;
    b_done = n_done;
    push_report(48'h0003_369C_0003);
    send_cmd(8'h52);
    guard = 0;
    while ((n_done - b_done < 2) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_report_two_bytes", 64'(n_done - b_done), 64'd2);
    chk("mid_report_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_cpu_ena",   {63'd0, cpu_ena},   64'd0);
    chk("abort_bip_reset", {63'd0, bip_reset}, 64'd0);
    chk("abort_tx_start",  {63'd0, tx_start},  64'd0);
    chk("abort_tx_data",   {56'd0, tx_data},   64'd0);
    chk("abort_halted",    {63'd0, halted},    64'd0);
    chk("abort_busy",      {63'd0, busy},      64'd0);
    exp_q.delete();
    b_tx = n_tx;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_bip_reset_release", {63'd0, bip_reset}, 64'd1);
    repeat (60) @(negedge clk);
    chk("abort_no_more_tx", 64'(n_tx - b_tx), 64'd0);

    // Counter saturation
    do_reset();
    halt_pc = -1;
    send_cmd(8'h52);
    repeat (65540) @(negedge clk);
    force_halt = 1'b1;
    push_report({16'(pc_m), acc_m, 16'hFFFF});
    repeat (80) @(negedge clk);
    force_halt = 1'b0;
    chk("sat_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("sat_halted",      {63'd0, halted},   64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
